// File: rtl/user_saxil_regfile.sv
// ---------------------------------------------------------------------------
// user_saxil_regfile
//   AXI4-Lite slave register file: NUM_REGS registers of DATA_W bits, with
//   byte-lane write strobes and independent, concurrently running read and
//   write state machines. Every output is driven from registered state only.
//
//   Optional build macro:
//     USER_SAXIL_SLVERR_EN  - out-of-range accesses answer SLVERR (reads
//                             return zero, writes change nothing). When the
//                             macro is absent the upper address bits are
//                             ignored, addresses alias onto the index bits,
//                             and every access answers OKAY.
// ---------------------------------------------------------------------------
module user_saxil_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                  user_saxil_clk,
    input  logic                  user_saxil_rst,

    // write address channel
    input  logic [ADDR_W-1:0]     user_port_awaddr,
    input  logic                  user_port_awvalid,
    output logic                  user_port_awready,

    // write data channel
    input  logic [DATA_W-1:0]     user_port_wdata,
    input  logic [DATA_W/8-1:0]   user_port_wstrb,
    input  logic                  user_port_wvalid,
    output logic                  user_port_wready,

    // write response channel
    output logic [1:0]            user_port_bresp,
    output logic                  user_port_bvalid,
    input  logic                  user_port_bready,

    // read address channel
    input  logic [ADDR_W-1:0]     user_port_araddr,
    input  logic                  user_port_arvalid,
    output logic                  user_port_arready,

    // read data channel
    output logic [DATA_W-1:0]     user_port_rdata,
    output logic [1:0]            user_port_rresp,
    output logic                  user_port_rvalid,
    input  logic                  user_port_rready
);

    // -----------------------------------------------------------------------
    // Geometry and encodings
    // -----------------------------------------------------------------------
    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_B = $clog2(STRB_W);    // byte-offset bits, ignored
    localparam int IDX_W  = $clog2(NUM_REGS);  // register index bits

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;

`ifdef USER_SAXIL_SLVERR_EN
    // Byte span decoded by this block; anything at or above it is an error.
    localparam logic [63:0] ADDR_SPAN = 64'(NUM_REGS * STRB_W);
`endif

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              live;        // low during reset, high from the first cycle after
    logic [0:0]        r_state;
    logic [0:0]        w_state;

    logic              aw_done;     // write address captured, waiting for data
    logic              w_done;      // write data captured, waiting for address
    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;

    // Decoded access information
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_ok;
    logic              rd_ok;
    logic              wr_commit;

    // Address bits outside the index field only feed the optional range check.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{aw_addr, user_port_araddr};

    // -----------------------------------------------------------------------
    // Ready outputs: derived purely from registered state. The live flag
    // keeps every ready low through reset and releases them together on
    // the first cycle after reset drops.
    // -----------------------------------------------------------------------
    assign user_port_arready = live && (r_state == R_IDLE);
    assign user_port_awready = live && (w_state == W_IDLE) && !aw_done;
    assign user_port_wready  = live && (w_state == W_IDLE) && !w_done;

    // Track whether the block has come out of reset.
    always_ff @(posedge user_saxil_clk) begin
        // NOTE: sequential state is assigned with <= so every flop samples
        // pre-edge values; this is also what lets a read issued in the same
        // cycle as a write commit observe the register's old contents.
        if (user_saxil_rst) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // Decode register index, range status and the write commit strobe.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through it can leave a value unassigned and infer a latch.
        wr_idx    = aw_addr[IDX_W+LANE_B-1:LANE_B];
        rd_idx    = user_port_araddr[IDX_W+LANE_B-1:LANE_B];
        wr_ok     = 1'b1;
        rd_ok     = 1'b1;
        wr_commit = (w_state == W_IDLE) && aw_done && w_done;
`ifdef USER_SAXIL_SLVERR_EN
        wr_ok     = 64'(aw_addr) < ADDR_SPAN;
        rd_ok     = 64'(user_port_araddr) < ADDR_SPAN;
`endif
    end

    // -----------------------------------------------------------------------
    // Write path
    // -----------------------------------------------------------------------

    // Write FSM: collect AW and W in any order, commit, then hold the response.
    always_ff @(posedge user_saxil_clk) begin
        if (user_saxil_rst) begin
            w_state          <= W_IDLE;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            aw_addr          <= '0;
            w_data           <= '0;
            w_strb           <= '0;
            user_port_bvalid <= 1'b0;
            user_port_bresp  <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (user_port_awready && user_port_awvalid) begin
                        aw_addr <= user_port_awaddr;
                        aw_done <= 1'b1;
                    end
                    if (user_port_wready && user_port_wvalid) begin
                        w_data <= user_port_wdata;
                        w_strb <= user_port_wstrb;
                        w_done <= 1'b1;
                    end
                    // Both halves were held from an earlier cycle: the
                    // register update happens now and the response follows.
                    if (wr_commit) begin
                        aw_done          <= 1'b0;
                        w_done           <= 1'b0;
                        user_port_bvalid <= 1'b1;
                        user_port_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        w_state          <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (user_port_bready) begin
                        user_port_bvalid <= 1'b0;
                        w_state          <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Register array: cleared by reset, byte lanes updated on commit.
    always_ff @(posedge user_saxil_clk) begin
        // NOTE: this array is a set of software-visible registers that must
        // read zero after reset, so it is built from resettable flops rather
        // than a RAM macro, which could not be cleared in one cycle.
        if (user_saxil_rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_commit && wr_ok) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb[i]) begin
                    regs[wr_idx][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------

    // Read FSM: sample the register on the AR handshake, hold until accepted.
    always_ff @(posedge user_saxil_clk) begin
        if (user_saxil_rst) begin
            r_state          <= R_IDLE;
            user_port_rvalid <= 1'b0;
            user_port_rdata  <= '0;
            user_port_rresp  <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (user_port_arready && user_port_arvalid) begin
                        r_state          <= R_DATA;
                        user_port_rvalid <= 1'b1;
                        user_port_rdata  <= rd_ok ? regs[rd_idx] : '0;
                        user_port_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_DATA: begin
                    if (user_port_rready) begin
                        user_port_rvalid <= 1'b0;
                        r_state          <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_saxil_regfile.sv
// ---------------------------------------------------------------------------
// tb_user_saxil_regfile
//   Directed self-checking bench for user_saxil_regfile (DATA_W=32,
//   NUM_REGS=16). Inputs are driven and outputs sampled on the falling edge.
//   Expectations for out-of-range accesses follow USER_SAXIL_SLVERR_EN.
// ---------------------------------------------------------------------------
module tb_user_saxil_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] awaddr  = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata   = '0;
    logic [3:0]  wstrb   = '0;
    logic        wvalid  = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready  = 1'b0;
    logic [31:0] araddr  = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready  = 1'b0;

    int checks = 0;
    int errors = 0;

`ifdef USER_SAXIL_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    always #5 clk = ~clk;

    user_saxil_regfile #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .NUM_REGS (16)
    ) dut (
        .user_saxil_clk    (clk),
        .user_saxil_rst    (rst),
        .user_port_awaddr  (awaddr),
        .user_port_awvalid (awvalid),
        .user_port_awready (awready),
        .user_port_wdata   (wdata),
        .user_port_wstrb   (wstrb),
        .user_port_wvalid  (wvalid),
        .user_port_wready  (wready),
        .user_port_bresp   (bresp),
        .user_port_bvalid  (bvalid),
        .user_port_bready  (bready),
        .user_port_araddr  (araddr),
        .user_port_arvalid (arvalid),
        .user_port_arready (arready),
        .user_port_rdata   (rdata),
        .user_port_rresp   (rresp),
        .user_port_rvalid  (rvalid),
        .user_port_rready  (rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full read transaction; starts and ends on a falling edge.
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n;
        araddr  = addr;
        arvalid = 1'b1;
        check({tag, "_arready"}, arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, 0);
        check({tag, "_rdata"}, rdata, exp_data);
        check({tag, "_rresp"}, rresp, exp_resp);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check({tag, "_rvalid_clr"}, rvalid, 0);
    endtask

    // Full write transaction with AW and W together; starts/ends on a falling edge.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        int n;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        check({tag, "_aw_w_ready"}, {awready, wready}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        while (!bvalid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_blat"}, n, 1);
        check({tag, "_bresp"}, bresp, exp_resp);
        check({tag, "_ready_in_resp"}, {awready, wready}, 2'b00);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check({tag, "_bvalid_clr"}, bvalid, 0);
    endtask

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_readies", {arready, awready, wready}, 3'b000);
        check("rst_valids", {rvalid, bvalid}, 2'b00);
        check("rst_rdata", rdata, 0);
        check("rst_resps", {rresp, bresp}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_readies", {arready, awready, wready}, 3'b111);

        // Read of index 3 straight after reset
        do_read("rd_idx3_reset", 32'h0000_000C, 32'h0, 2'b00);

        // Full write then single-byte overwrite of index 2
        do_write("wr8_full", 32'h8, 32'hDEAD_BEEF, 4'b1111, 2'b00);
        do_write("wr8_byte0", 32'h8, 32'h0000_00AA, 4'b0001, 2'b00);
        do_read("rd8", 32'h8, 32'hDEAD_BEAA, 2'b00);
        do_read("rd8_unaligned", 32'hB, 32'hDEAD_BEAA, 2'b00);

        // Middle byte lanes only
        do_write("wr_c_mid", 32'hC, 32'hAABB_CCDD, 4'b0110, 2'b00);
        do_read("rd_c_mid", 32'hC, 32'h00BB_CC00, 2'b00);

        // W three cycles ahead of AW
        wdata  = 32'h1234_5678;
        wstrb  = 4'b1111;
        wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("wfirst_wready_drop", wready, 0);
        check("wfirst_awready", awready, 1);
        repeat (2) begin
            @(negedge clk);
            check("wfirst_hold", {wready, bvalid}, 2'b00);
        end
        awaddr  = 32'h4;
        awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("wfirst_blat", n, 1);
        check("wfirst_bresp", bresp, 2'b00);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        do_read("rd4_wfirst", 32'h4, 32'h1234_5678, 2'b00);

        // Zero strobe leaves the register alone
        do_write("wr4_nostrb", 32'h4, 32'hFFFF_FFFF, 4'b0000, 2'b00);
        do_read("rd4_nostrb", 32'h4, 32'h1234_5678, 2'b00);

        // Read data held under backpressure; next AR waits for the handshake
        araddr  = 32'h8;
        arvalid = 1'b1;
        @(negedge clk);
        araddr  = 32'h4;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_rvalid_%0d", i), rvalid, 1);
            check($sformatf("bp_rdata_%0d", i), rdata, 32'hDEAD_BEAA);
            check($sformatf("bp_rresp_%0d", i), rresp, 2'b00);
            check($sformatf("bp_arready_%0d", i), arready, 0);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("bp_rvalid_after", rvalid, 0);
        check("bp_arready_after", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        check("bp_next_rvalid", rvalid, 1);
        check("bp_next_rdata", rdata, 32'h1234_5678);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;

        // Read sampled in the commit cycle returns the pre-write value
        awaddr  = 32'h8;
        wdata   = 32'h1111_1111;
        wstrb   = 4'b1111;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        araddr  = 32'h8;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check("rw_same_bvalid", bvalid, 1);
        check("rw_same_rvalid", rvalid, 1);
        check("rw_same_rdata_old", rdata, 32'hDEAD_BEAA);
        rready = 1'b1;
        bready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        bready = 1'b0;
        check("rw_same_clr", {rvalid, bvalid}, 2'b00);
        do_read("rd8_new", 32'h8, 32'h1111_1111, 2'b00);

        // Out-of-range accesses
        do_write("wr0", 32'h0, 32'hCAFE_F00D, 4'b1111, 2'b00);
`ifdef USER_SAXIL_SLVERR_EN
        do_read("rd_oor_100", 32'h100, 32'h0, OOR_RESP);
        do_write("wr_oor_104", 32'h104, 32'h0000_5555, 4'b1111, OOR_RESP);
        do_read("rd4_after_oor", 32'h4, 32'h1234_5678, 2'b00);
`else
        do_read("rd_oor_100", 32'h100, 32'hCAFE_F00D, OOR_RESP);
        do_write("wr_oor_104", 32'h104, 32'h0000_5555, 4'b1111, OOR_RESP);
        do_read("rd4_after_oor", 32'h4, 32'h0000_5555, 2'b00);
`endif

        // Reset while a write response is pending
        awaddr  = 32'h8;
        wdata   = 32'h0000_0077;
        wstrb   = 4'b1111;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        @(negedge clk);
        check("rstmid_bvalid_before", bvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_bvalid", bvalid, 0);
        check("rstmid_readies", {arready, awready, wready}, 3'b000);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_readies_back", {arready, awready, wready}, 3'b111);
        for (int r = 0; r < 16; r++) begin
            do_read($sformatf("rstmid_reg%0d", r), 32'(r * 4), 32'h0, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
